// File: rtl/fejkon_pcie_pkg.sv
// rtl/fejkon_pcie_pkg.sv - shared TLP types, constants and header struct for the BAR0 request engine
package fejkon_pcie_pkg;

    // Decoded TLP kind; only MRD/MWR are executed, CPL/CPLD are silently ignored.
    typedef enum logic [2:0] {
        MRD,
        MWR,
        CPL,
        CPLD,
        UNKNOWN
    } tlp_t;

    // fmt[1] = has data, fmt[0] = 4DW header
    localparam logic [1:0] FMT_3DW_NODATA = 2'b00;
    localparam logic [1:0] FMT_4DW_NODATA = 2'b01;
    localparam logic [1:0] FMT_3DW_DATA   = 2'b10;
    localparam logic [1:0] FMT_4DW_DATA   = 2'b11;

    localparam logic [4:0] TYPE_MEM = 5'b00000;
    localparam logic [4:0] TYPE_CPL = 5'b01010;

    localparam logic [2:0] CPL_SC = 3'b000;
    localparam logic [2:0] CPL_UR = 3'b001;
    localparam logic [2:0] CPL_CA = 3'b100;

    typedef struct packed {
        logic [1:0]  fmt;
        logic [4:0]  typ;
        logic [9:0]  len;
        logic [15:0] req_id;
        logic [7:0]  tag;
        logic [3:0]  first_be;
    } tlp_hdr_t;

    function automatic logic [31:0] get_dw(input logic [255:0] beat, input int idx);
        return beat[32*idx +: 32];
    endfunction

endpackage

// File: rtl/fejkon_pcie_tlp_hdr_decode.sv
// rtl/fejkon_pcie_tlp_hdr_decode.sv - combinational decode of the first TLP beat
//
// Ports:
//   data_i      256-bit first beat, dword i at [32i+31:32i]
//   bar0_hit_i  request targets BAR0
//   type_o      decoded TLP kind
//   is_4dw_o    4DW header
//   hdr_o       raw header fields (fmt, type, len, requester id, tag, first BE)
//   addr_o      dword-aligned byte address
//   wdata_o     MWr payload dword picked by header size and address QW alignment
//   supported_o single-DW MRd/MWr hitting BAR0 with a valid 4DW upper address
module fejkon_pcie_tlp_hdr_decode
    import fejkon_pcie_pkg::*;
(
    input  logic [255:0] data_i,
    input  logic         bar0_hit_i,
    output tlp_t         type_o,
    output logic         is_4dw_o,
    output tlp_hdr_t     hdr_o,
    output logic [31:0]  addr_o,
    output logic [31:0]  wdata_o,
    output logic         supported_o
);

    logic [31:0] dw0, dw1, dw2, dw3, dw4, dw5;
    logic        unused_bits;

    assign dw0 = get_dw(data_i, 0);
    assign dw1 = get_dw(data_i, 1);
    assign dw2 = get_dw(data_i, 2);
    assign dw3 = get_dw(data_i, 3);
    assign dw4 = get_dw(data_i, 4);
    assign dw5 = get_dw(data_i, 5);

    assign unused_bits = ^{data_i[255:192], dw0[31], dw0[23:10], dw1[7:4]};

    always_comb begin
        hdr_o          = '0;
        hdr_o.fmt      = dw0[30:29];
        hdr_o.typ      = dw0[28:24];
        hdr_o.len      = dw0[9:0];
        hdr_o.req_id   = dw1[31:16];
        hdr_o.tag      = dw1[15:8];
        hdr_o.first_be = dw1[3:0];

        is_4dw_o = hdr_o.fmt[0];

        type_o = UNKNOWN;
        if (hdr_o.typ == TYPE_MEM) begin
            type_o = hdr_o.fmt[1] ? MWR : MRD;
        end else if (hdr_o.typ == TYPE_CPL) begin
            type_o = hdr_o.fmt[1] ? CPLD : CPL;
        end

        addr_o = is_4dw_o ? {dw3[31:2], 2'b00} : {dw2[31:2], 2'b00};

        // Payload starts QW-aligned after the header: a 3DW header leaves
        // dw3 as the odd slot, a 4DW header fills through dw3.
        if (is_4dw_o) begin
            wdata_o = addr_o[2] ? dw5 : dw4;
        end else begin
            wdata_o = addr_o[2] ? dw3 : dw4;
        end

        supported_o = bar0_hit_i && (hdr_o.len == 10'd1) &&
                      (type_o == MRD || type_o == MWR) &&
                      (!is_4dw_o || dw2 == 32'd0);
    end

endmodule

// File: rtl/fejkon_pcie_bar0_req.sv
// rtl/fejkon_pcie_bar0_req.sv - BAR0 MRd/MWr request engine from rx_st to Avalon-MM with completion descriptors
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   rx_st_*                Avalon-ST TLP input from the hard IP (rx_st_empty unused)
//   bar0_mm_*              Avalon-MM master executing single-DW accesses
//   cpl_*                  completion descriptor for every non-posted request
//   stat_ur_count          saturating count of unsupported/dropped TLPs
module fejkon_pcie_bar0_req
    import fejkon_pcie_pkg::*;
#(
    parameter int BAR0_AW    = 16,
    parameter int RD_TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] rx_st_data,
    input  logic         rx_st_valid,
    input  logic         rx_st_startofpacket,
    input  logic         rx_st_endofpacket,
    input  logic [1:0]   rx_st_empty,
    input  logic [7:0]   rx_st_bar,
    output logic         rx_st_ready,
    output logic [31:0]  bar0_mm_address,
    output logic         bar0_mm_read,
    output logic         bar0_mm_write,
    output logic [31:0]  bar0_mm_writedata,
    input  logic         bar0_mm_waitrequest,
    input  logic [31:0]  bar0_mm_readdata,
    input  logic         bar0_mm_readdatavalid,
    output logic         cpl_valid,
    input  logic         cpl_ready,
    output logic [15:0]  cpl_requester_id,
    output logic [7:0]   cpl_tag,
    output logic [6:0]   cpl_lower_addr,
    output logic [2:0]   cpl_status,
    output logic [31:0]  cpl_data,
    output logic [15:0]  stat_ur_count
);

    localparam int TW = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_MM_WR,
        ST_MM_RD,
        ST_RD_WAIT,
        ST_CPL
    } state_t;

    state_t               state_q, state_d;
    logic [BAR0_AW-1:2]   addr_q, addr_d;
    logic [6:2]           la_q, la_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          cdata_q, cdata_d;
    logic [15:0]          reqid_q, reqid_d;
    logic [7:0]           tag_q, tag_d;
    logic [2:0]           status_q, status_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 ur_inc;

    tlp_t                 dec_type;
    logic                 dec_is_4dw;
    tlp_hdr_t             dec_hdr;
    logic [31:0]          dec_addr;
    logic [31:0]          dec_wdata;
    logic                 dec_supported;
    logic                 dec_is_cpl;
    logic                 unused_bits;

    fejkon_pcie_tlp_hdr_decode u_decode (
        .data_i      (rx_st_data),
        .bar0_hit_i  (rx_st_bar[0]),
        .type_o      (dec_type),
        .is_4dw_o    (dec_is_4dw),
        .hdr_o       (dec_hdr),
        .addr_o      (dec_addr),
        .wdata_o     (dec_wdata),
        .supported_o (dec_supported)
    );

    assign unused_bits = ^{rx_st_empty, rx_st_bar[7:1], dec_is_4dw, dec_hdr, dec_addr};
    assign dec_is_cpl  = (dec_type == CPL) || (dec_type == CPLD);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        la_d     = la_q;
        wdata_d  = wdata_q;
        cdata_d  = cdata_q;
        reqid_d  = reqid_q;
        tag_d    = tag_q;
        status_d = status_q;
        timer_d  = timer_q;
        ur_inc   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_st_valid && rx_st_startofpacket) begin
                    if (!rx_st_endofpacket) begin
                        state_d = ST_DRAIN;
                        ur_inc  = !dec_is_cpl;
                    end else if (dec_supported && dec_type == MWR && dec_hdr.first_be == 4'hF) begin
                        state_d = ST_MM_WR;
                        addr_d  = dec_addr[BAR0_AW-1:2];
                        wdata_d = dec_wdata;
                    end else if (dec_type == MRD) begin
                        la_d    = dec_addr[6:2];
                        reqid_d = dec_hdr.req_id;
                        tag_d   = dec_hdr.tag;
                        if (dec_supported) begin
                            state_d = ST_MM_RD;
                            addr_d  = dec_addr[BAR0_AW-1:2];
                        end else begin
                            state_d  = ST_CPL;
                            status_d = CPL_UR;
                            cdata_d  = 32'd0;
                            ur_inc   = 1'b1;
                        end
                    end else begin
                        ur_inc = !dec_is_cpl;
                    end
                end
            end
            ST_DRAIN: begin
                if (rx_st_valid && rx_st_endofpacket) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MM_WR: begin
                if (!bar0_mm_waitrequest) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MM_RD: begin
                if (!bar0_mm_waitrequest) begin
                    state_d = ST_RD_WAIT;
                    timer_d = '0;
                end
            end
            ST_RD_WAIT: begin
                timer_d = timer_q + TW'(1);
                // Data arriving on the expiry cycle takes priority over the abort.
                if (bar0_mm_readdatavalid) begin
                    state_d  = ST_CPL;
                    status_d = CPL_SC;
                    cdata_d  = bar0_mm_readdata;
                end else if (timer_q == TW'(RD_TIMEOUT - 1)) begin
                    state_d  = ST_CPL;
                    status_d = CPL_CA;
                    cdata_d  = 32'd0;
                end
            end
            ST_CPL: begin
                if (cpl_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cnt_d = cnt_q;
        if (ur_inc && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            la_q     <= '0;
            wdata_q  <= '0;
            cdata_q  <= '0;
            reqid_q  <= '0;
            tag_q    <= '0;
            status_q <= '0;
            timer_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            la_q     <= la_d;
            wdata_q  <= wdata_d;
            cdata_q  <= cdata_d;
            reqid_q  <= reqid_d;
            tag_q    <= tag_d;
            status_q <= status_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
        end
    end

    // Ready is gated by reset so the hard IP never sees a stray accept while held in reset.
    assign rx_st_ready       = !reset && (state_q == ST_IDLE || state_q == ST_DRAIN);
    assign bar0_mm_read      = (state_q == ST_MM_RD);
    assign bar0_mm_write     = (state_q == ST_MM_WR);
    assign bar0_mm_address   = {{(32 - BAR0_AW){1'b0}}, addr_q, 2'b00};
    assign bar0_mm_writedata = wdata_q;
    assign cpl_valid         = (state_q == ST_CPL);
    assign cpl_requester_id  = reqid_q;
    assign cpl_tag           = tag_q;
    assign cpl_lower_addr    = {la_q, 2'b00};
    assign cpl_status        = status_q;
    assign cpl_data          = cdata_q;
    assign stat_ur_count     = cnt_q;

endmodule

// File: tb/tb_fejkon_pcie_bar0_req.sv
// tb/tb_fejkon_pcie_bar0_req.sv - scoreboard testbench for fejkon_pcie_bar0_req
module tb_fejkon_pcie_bar0_req;

    localparam int RD_TO = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] rx_st_data;
    logic         rx_st_valid, rx_st_startofpacket, rx_st_endofpacket;
    logic [1:0]   rx_st_empty;
    logic [7:0]   rx_st_bar;
    logic         rx_st_ready;
    logic [31:0]  bar0_mm_address;
    logic         bar0_mm_read, bar0_mm_write;
    logic [31:0]  bar0_mm_writedata;
    logic         bar0_mm_waitrequest;
    logic [31:0]  bar0_mm_readdata;
    logic         bar0_mm_readdatavalid;
    logic         cpl_valid, cpl_ready;
    logic [15:0]  cpl_requester_id;
    logic [7:0]   cpl_tag;
    logic [6:0]   cpl_lower_addr;
    logic [2:0]   cpl_status;
    logic [31:0]  cpl_data;
    logic [15:0]  stat_ur_count;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [2:0]  status;
        logic [31:0] data;
        logic [6:0]  la;
        logic [7:0]  tag;
        logic [15:0] reqid;
    } cpl_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    cpl_t cpl_q[$];
    wr_t  wr_q[$];

    always #5 clk = ~clk;

    fejkon_pcie_bar0_req #(.BAR0_AW(16), .RD_TIMEOUT(RD_TO)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .rx_st_data            (rx_st_data),
        .rx_st_valid           (rx_st_valid),
        .rx_st_startofpacket   (rx_st_startofpacket),
        .rx_st_endofpacket     (rx_st_endofpacket),
        .rx_st_empty           (rx_st_empty),
        .rx_st_bar             (rx_st_bar),
        .rx_st_ready           (rx_st_ready),
        .bar0_mm_address       (bar0_mm_address),
        .bar0_mm_read          (bar0_mm_read),
        .bar0_mm_write         (bar0_mm_write),
        .bar0_mm_writedata     (bar0_mm_writedata),
        .bar0_mm_waitrequest   (bar0_mm_waitrequest),
        .bar0_mm_readdata      (bar0_mm_readdata),
        .bar0_mm_readdatavalid (bar0_mm_readdatavalid),
        .cpl_valid             (cpl_valid),
        .cpl_ready             (cpl_ready),
        .cpl_requester_id      (cpl_requester_id),
        .cpl_tag               (cpl_tag),
        .cpl_lower_addr        (cpl_lower_addr),
        .cpl_status            (cpl_status),
        .cpl_data              (cpl_data),
        .stat_ur_count         (stat_ur_count)
    );

    function automatic logic [255:0] mk_tlp(input logic [1:0] fmt, input logic [4:0] typ,
                                            input logic [9:0] len, input logic [15:0] rid,
                                            input logic [7:0] tag, input logic [3:0] be,
                                            input logic [31:0] d2, input logic [31:0] d3,
                                            input logic [31:0] d4, input logic [31:0] d5);
        logic [255:0] b;
        b = '0;
        b[31:0]    = {1'b0, fmt, typ, 14'd0, len};
        b[63:32]   = {rid, tag, 4'h0, be};
        b[95:64]   = d2;
        b[127:96]  = d3;
        b[159:128] = d4;
        b[191:160] = d5;
        return b;
    endfunction

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic send_beat(input logic [255:0] d, input logic sop, input logic eop, input logic [7:0] bar);
        int n;
        rx_st_data          = d;
        rx_st_startofpacket = sop;
        rx_st_endofpacket   = eop;
        rx_st_bar           = bar;
        rx_st_valid         = 1'b1;
        n = 0;
        while (!rx_st_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!rx_st_ready) begin
            errors++;
            $display("FAIL rx_accept: rx_st_ready=%b required 1 within 100 cycles", rx_st_ready);
        end
        @(negedge clk);
        rx_st_valid         = 1'b0;
        rx_st_startofpacket = 1'b0;
        rx_st_endofpacket   = 1'b0;
    endtask

    task automatic serve_read(input int waits, input logic [31:0] d, output logic [31:0] addr_seen);
        int n;
        n = 0;
        while (!bar0_mm_read && n < 100) begin
            @(negedge clk);
            n++;
        end
        addr_seen = bar0_mm_address;
        bar0_mm_waitrequest = 1'b1;
        repeat (waits) @(negedge clk);
        bar0_mm_waitrequest = 1'b0;
        @(negedge clk);
        bar0_mm_readdatavalid = 1'b1;
        bar0_mm_readdata      = d;
        @(negedge clk);
        bar0_mm_readdatavalid = 1'b0;
    endtask

    task automatic take_cpl(output cpl_t got, output bit ok, output int waited);
        waited = 0;
        while (!cpl_valid && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        ok  = cpl_valid;
        got = '{cpl_status, cpl_data, cpl_lower_addr, cpl_tag, cpl_requester_id};
        if (ok) begin
            cpl_ready = 1'b1;
            @(negedge clk);
            cpl_ready = 1'b0;
        end
    endtask

    task automatic take_wr(output wr_t got, output bit ok, output bit stable);
        int n;
        wr_t first;
        n = 0;
        while (!bar0_mm_write && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = bar0_mm_write;
        first = '{bar0_mm_address, bar0_mm_writedata};
        bar0_mm_waitrequest = 1'b1;
        @(negedge clk);
        got = '{bar0_mm_address, bar0_mm_writedata};
        stable = bar0_mm_write && (got === first);
        bar0_mm_waitrequest = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({rx_st_ready, bar0_mm_read, bar0_mm_write, cpl_valid, stat_ur_count, bar0_mm_address} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rd=%b wr=%b cv=%b cnt=%h addr=%h required all 0",
                     rx_st_ready, bar0_mm_read, bar0_mm_write, cpl_valid, stat_ur_count, bar0_mm_address);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (rx_st_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", rx_st_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_mrd_waitstate();
        cpl_t got, exp_c;
        bit ok;
        int w;
        logic [31:0] a;
        cpl_q.push_back('{3'b000, 32'h12345678, 7'h10, 8'h2A, 16'h0100});
        send_beat(mk_tlp(2'b00, 5'd0, 10'd1, 16'h0100, 8'h2A, 4'hF, 32'h10, 0, 0, 0), 1'b1, 1'b1, 8'h01);
        serve_read(2, 32'h12345678, a);
        checks++;
        if (a !== 32'h10) begin
            errors++;
            $display("FAIL mrd_address: got %h required 00000010", a);
        end
        take_cpl(got, ok, w);
        exp_c = cpl_q.pop_front();
        checks++;
        if (!ok || got !== exp_c) begin
            errors++;
            $display("FAIL mrd_cpl: ok=%0d got %h required %h", ok, got, exp_c);
        end
    endtask

    task automatic test_mrd_latency();
        cpl_t got, exp_c;
        bit ok;
        int w;
        cpl_q.push_back('{3'b000, 32'hFEEDBEEF, 7'h7C, 8'h05, 16'hABCD});
        bar0_mm_waitrequest = 1'b0;
        send_beat(mk_tlp(2'b00, 5'd0, 10'd1, 16'hABCD, 8'h05, 4'hF, 32'h0000_FFFC, 0, 0, 0), 1'b1, 1'b1, 8'h01);
        checks++;
        if (bar0_mm_read !== 1'b1 || bar0_mm_address !== 32'h0000_FFFC) begin
            errors++;
            $display("FAIL lat_read_n1: read=%b addr=%h required 1 0000fffc", bar0_mm_read, bar0_mm_address);
        end
        @(negedge clk);
        bar0_mm_readdatavalid = 1'b1;
        bar0_mm_readdata      = 32'hFEEDBEEF;
        @(negedge clk);
        bar0_mm_readdatavalid = 1'b0;
        checks++;
        if (cpl_valid !== 1'b1) begin
            errors++;
            $display("FAIL lat_cpl_n3: cpl_valid=%b required 1", cpl_valid);
        end
        take_cpl(got, ok, w);
        exp_c = cpl_q.pop_front();
        checks++;
        if (!ok || got !== exp_c) begin
            errors++;
            $display("FAIL lat_cpl: ok=%0d got %h required %h", ok, got, exp_c);
        end
    endtask

    task automatic test_mwr();
        wr_t got, exp_w;
        bit ok, stable;
        bit no_cpl;
        wr_q.push_back('{32'h4, 32'hCAFEF00D});
        wr_q.push_back('{32'h8, 32'h0BADBEEF});
        wr_q.push_back('{32'h10, 32'h55AA55AA});
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: send_beat(mk_tlp(2'b10, 5'd0, 10'd1, 16'h1, 8'h1, 4'hF, 32'h4, 32'hCAFEF00D, 32'hDEAD0001, 0), 1'b1, 1'b1, 8'h01);
                1: send_beat(mk_tlp(2'b10, 5'd0, 10'd1, 16'h1, 8'h2, 4'hF, 32'h8, 32'hDEAD0002, 32'h0BADBEEF, 0), 1'b1, 1'b1, 8'h01);
                default: send_beat(mk_tlp(2'b11, 5'd0, 10'd1, 16'h1, 8'h3, 4'hF, 32'h0, 32'h10, 32'h55AA55AA, 32'hDEAD0003), 1'b1, 1'b1, 8'h01);
            endcase
            take_wr(got, ok, stable);
            exp_w = wr_q.pop_front();
            checks++;
            if (!ok || !stable || got !== exp_w) begin
                errors++;
                $display("FAIL mwr_%0d: ok=%0d stable=%0d got %h required %h", i, ok, stable, got, exp_w);
            end
        end
        no_cpl = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (cpl_valid !== 1'b0) no_cpl = 1'b0;
        end
        checks++;
        if (!no_cpl) begin
            errors++;
            $display("FAIL mwr_no_cpl: cpl_valid seen high, required low");
        end
    endtask

    task automatic test_unsupported();
        cpl_t got, exp_c;
        bit ok;
        int w;
        bit ready_all;
        bit no_write;
        cpl_q.push_back('{3'b001, 32'h0, 7'h44, 8'h11, 16'h0200});
        send_beat(mk_tlp(2'b00, 5'd0, 10'd2, 16'h0200, 8'h11, 4'hF, 32'h44, 0, 0, 0), 1'b1, 1'b1, 8'h01);
        take_cpl(got, ok, w);
        exp_c = cpl_q.pop_front();
        checks++;
        if (!ok || got !== exp_c) begin
            errors++;
            $display("FAIL ur_cpl: ok=%0d got %h required %h", ok, got, exp_c);
        end
        checks++;
        if (stat_ur_count !== 16'd1) begin
            errors++;
            $display("FAIL ur_count1: got %0d required 1", stat_ur_count);
        end
        ready_all = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (rx_st_ready !== 1'b1) ready_all = 1'b0;
            send_beat(mk_tlp(2'b10, 5'd0, 10'd16, 16'h1, 8'h1, 4'hF, 32'h40, 0, 0, 0), i == 0, i == 2, 8'h01);
        end
        if (rx_st_ready !== 1'b1) ready_all = 1'b0;
        checks++;
        if (!ready_all || stat_ur_count !== 16'd2 || bar0_mm_write !== 1'b0) begin
            errors++;
            $display("FAIL drain: ready_all=%0d count=%0d wr=%b required 1 2 0", ready_all, stat_ur_count, bar0_mm_write);
        end
        no_write = 1'b1;
        send_beat(mk_tlp(2'b10, 5'd0, 10'd1, 16'h1, 8'h1, 4'h7, 32'h40, 32'h1, 32'h2, 0), 1'b1, 1'b1, 8'h01);
        repeat (2) begin
            if (bar0_mm_write !== 1'b0) no_write = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!no_write || stat_ur_count !== 16'd3) begin
            errors++;
            $display("FAIL partial_be_drop: no_write=%0d count=%0d required 1 3", no_write, stat_ur_count);
        end
        send_beat(mk_tlp(2'b10, 5'b01010, 10'd1, 16'h1, 8'h1, 4'hF, 32'h0, 32'h0, 0, 0), 1'b1, 1'b1, 8'h01);
        @(negedge clk);
        checks++;
        if (stat_ur_count !== 16'd3 || cpl_valid !== 1'b0) begin
            errors++;
            $display("FAIL cpld_ignored: count=%0d cv=%b required 3 0", stat_ur_count, cpl_valid);
        end
    endtask

    task automatic test_timeout();
        cpl_t got, exp_c;
        bit ok;
        int w;
        bar0_mm_waitrequest = 1'b0;
        cpl_q.push_back('{3'b100, 32'h0, 7'h20, 8'h33, 16'h0300});
        send_beat(mk_tlp(2'b00, 5'd0, 10'd1, 16'h0300, 8'h33, 4'hF, 32'h20, 0, 0, 0), 1'b1, 1'b1, 8'h01);
        repeat (RD_TO) @(negedge clk);
        checks++;
        if (cpl_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: cpl_valid=%b required 0 in last RD_WAIT cycle", cpl_valid);
        end
        take_cpl(got, ok, w);
        exp_c = cpl_q.pop_front();
        checks++;
        if (!ok || w != 1 || got !== exp_c) begin
            errors++;
            $display("FAIL timeout_ca: ok=%0d wait=%0d got %h required wait 1 %h", ok, w, got, exp_c);
        end
        bar0_mm_readdatavalid = 1'b1;
        bar0_mm_readdata      = 32'hBAD0BAD0;
        @(negedge clk);
        bar0_mm_readdatavalid = 1'b0;
        @(negedge clk);
        checks++;
        if (cpl_valid !== 1'b0 || rx_st_ready !== 1'b1) begin
            errors++;
            $display("FAIL late_rdv: cv=%b ready=%b required 0 1", cpl_valid, rx_st_ready);
        end
        cpl_q.push_back('{3'b000, 32'hA5A50001, 7'h24, 8'h34, 16'h0300});
        send_beat(mk_tlp(2'b00, 5'd0, 10'd1, 16'h0300, 8'h34, 4'hF, 32'h24, 0, 0, 0), 1'b1, 1'b1, 8'h01);
        repeat (RD_TO) @(negedge clk);
        bar0_mm_readdatavalid = 1'b1;
        bar0_mm_readdata      = 32'hA5A50001;
        @(negedge clk);
        bar0_mm_readdatavalid = 1'b0;
        take_cpl(got, ok, w);
        exp_c = cpl_q.pop_front();
        checks++;
        if (!ok || w != 0 || got !== exp_c) begin
            errors++;
            $display("FAIL expiry_rdv_wins: ok=%0d wait=%0d got %h required wait 0 %h", ok, w, got, exp_c);
        end
    endtask

    task automatic test_backpressure();
        cpl_t got, exp_c, snap, now;
        bit ok, stable;
        int w, n;
        logic [31:0] a;
        cpl_q.push_back('{3'b000, 32'h00000077, 7'h30, 8'h44, 16'h0400});
        send_beat(mk_tlp(2'b00, 5'd0, 10'd1, 16'h0400, 8'h44, 4'hF, 32'h30, 0, 0, 0), 1'b1, 1'b1, 8'h01);
        serve_read(0, 32'h77, a);
        n = 0;
        while (!cpl_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        snap = '{cpl_status, cpl_data, cpl_lower_addr, cpl_tag, cpl_requester_id};
        stable = cpl_valid;
        repeat (10) begin
            @(negedge clk);
            now = '{cpl_status, cpl_data, cpl_lower_addr, cpl_tag, cpl_requester_id};
            if (now !== snap || cpl_valid !== 1'b1 || rx_st_ready !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL bp_stable: descriptor/ready changed under backpressure, now %h required %h", now, snap);
        end
        take_cpl(got, ok, w);
        exp_c = cpl_q.pop_front();
        checks++;
        if (!ok || got !== exp_c) begin
            errors++;
            $display("FAIL bp_cpl: ok=%0d got %h required %h", ok, got, exp_c);
        end
        checks++;
        if (rx_st_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_after: got %b required 1", rx_st_ready);
        end
        cpl_q.push_back('{3'b000, 32'h00000088, 7'h34, 8'h45, 16'h0400});
        send_beat(mk_tlp(2'b00, 5'd0, 10'd1, 16'h0400, 8'h45, 4'hF, 32'h34, 0, 0, 0), 1'b1, 1'b1, 8'h01);
        checks++;
        if (bar0_mm_read !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_accept: read=%b required 1", bar0_mm_read);
        end
        serve_read(0, 32'h88, a);
        take_cpl(got, ok, w);
        exp_c = cpl_q.pop_front();
        checks++;
        if (!ok || got !== exp_c) begin
            errors++;
            $display("FAIL bp_next_cpl: ok=%0d got %h required %h", ok, got, exp_c);
        end
    endtask

    task automatic test_reset_mid_read();
        cpl_t got, exp_c;
        bit ok, quiet;
        int w;
        logic [31:0] a;
        bar0_mm_waitrequest = 1'b1;
        send_beat(mk_tlp(2'b00, 5'd0, 10'd1, 16'h0500, 8'h55, 4'hF, 32'h50, 0, 0, 0), 1'b1, 1'b1, 8'h01);
        checks++;
        if (bar0_mm_read !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_read: read=%b required 1", bar0_mm_read);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bar0_mm_read !== 1'b0 || cpl_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_async_drop: read=%b cv=%b required 0 0", bar0_mm_read, cpl_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        bar0_mm_waitrequest = 1'b0;
        quiet = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (cpl_valid !== 1'b0 || bar0_mm_read !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL rst_no_cpl: activity after reset, required none");
        end
        cpl_q.push_back('{3'b000, 32'h13572468, 7'h58, 8'h56, 16'h0500});
        send_beat(mk_tlp(2'b00, 5'd0, 10'd1, 16'h0500, 8'h56, 4'hF, 32'h58, 0, 0, 0), 1'b1, 1'b1, 8'h01);
        serve_read(1, 32'h13572468, a);
        take_cpl(got, ok, w);
        exp_c = cpl_q.pop_front();
        checks++;
        if (!ok || got !== exp_c || a !== 32'h58) begin
            errors++;
            $display("FAIL rst_next_mrd: ok=%0d addr=%h got %h required 00000058 %h", ok, a, got, exp_c);
        end
    endtask

    initial begin
        reset                 = 1'b1;
        rx_st_data            = '0;
        rx_st_valid           = 1'b0;
        rx_st_startofpacket   = 1'b0;
        rx_st_endofpacket     = 1'b0;
        rx_st_empty           = 2'b00;
        rx_st_bar             = 8'h00;
        bar0_mm_waitrequest   = 1'b0;
        bar0_mm_readdata      = '0;
        bar0_mm_readdatavalid = 1'b0;
        cpl_ready             = 1'b0;

        test_reset();
        test_mrd_waitstate();
        test_mrd_latency();
        test_mwr();
        test_unsupported();
        test_timeout();
        test_backpressure();
        test_reset_mid_read();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
